// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the MIPS pipeline write-back stage:
//   - opcode / funct constants the write-back decode needs
//   - write-back FSM state enum {RUN, WAIT_LOAD}
//   - write-back value source enum
//   - register index width and default link register for JAL
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int REG_IDX_W        = 5;
  localparam int LINK_REG_DEFAULT = 31;

  // Opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  // R-type funct (inst[5:0])
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LOAD = 2'd2,
    SRC_PC   = 2'd3
  } wb_src_e;

endpackage

// File: rtl/load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
// Combinational load-data alignment for LB/LH/LW/LBU/LHU.
// Memory is big-endian: byte lane 0 is word[31:24], halfword lane 0 is
// word[31:16]. Misaligned LH/LW simply use the truncated address.
// Ports:
//   i_word   in  32  word read from data memory
//   i_addr   in  2   low effective-address bits
//   i_opcode in  6   load opcode
//   o_value  out 32  extended value for the register file
// -----------------------------------------------------------------------------
module load_extract
  import pipeline_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [5:0]  i_opcode,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[31:24];
    case (i_addr)
      2'd0:    w_byte = i_word[31:24];
      2'd1:    w_byte = i_word[23:16];
      2'd2:    w_byte = i_word[15:8];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr[1] ? i_word[15:0] : i_word[31:16];
  end

  always_comb begin
    o_value = i_word;
    case (i_opcode)
      OP_LB:   o_value = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_value = {24'd0, w_byte};
      OP_LH:   o_value = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_value = {16'd0, w_half};
      default: o_value = i_word;
    endcase
  end

endmodule

// File: rtl/stage_writeback.sv
// -----------------------------------------------------------------------------
// stage_writeback
// MEM/WB pipeline register and write-back stage of the five-stage MIPS
// pipeline. Latches MEM results, selects/extends the write-back value and
// drives the register-file write port. Stalls upstream while a load waits on
// data memory, with a timeout that sets a sticky load_err.
// Parameters:
//   LOAD_TIMEOUT  max WAIT_LOAD cycles before load_err sets (1..255)
//   LINK_REG      destination register for JAL
// Ports:
//   clock, reset (async, active-low)
//   flush_in, mem_valid, mem_inst, mem_new_pc, mem_alu_output,
//   mem_load_data, mem_load_ready, mem_inst_num, mem_inst_type  (MEM side)
//   reg_we, reg_waddr, reg_wdata                                (RF write)
//   stall_out, wb_valid, wb_inst_num, wb_inst_type,
//   retire_count, load_err                                      (status)
// Optional macro WB_FORWARD_EN adds fwd_valid/fwd_addr/fwd_data mirroring the
// write port for EX-stage forwarding.
// -----------------------------------------------------------------------------
module stage_writeback
  import pipeline_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16,
  parameter int LINK_REG     = LINK_REG_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush_in,
  input  logic                 mem_valid,
  input  logic [31:0]          mem_inst,
  input  logic [31:0]          mem_new_pc,
  input  logic [31:0]          mem_alu_output,
  input  logic [31:0]          mem_load_data,
  input  logic                 mem_load_ready,
  input  logic [3:0]           mem_inst_num,
  input  logic [3:0]           mem_inst_type,
  output logic                 reg_we,
  output logic [REG_IDX_W-1:0] reg_waddr,
  output logic [31:0]          reg_wdata,
  output logic                 stall_out,
  output logic                 wb_valid,
  output logic [3:0]           wb_inst_num,
  output logic [3:0]           wb_inst_type,
  output logic [31:0]          retire_count,
  output logic                 load_err
`ifdef WB_FORWARD_EN
  ,
  output logic                 fwd_valid,
  output logic [REG_IDX_W-1:0] fwd_addr,
  output logic [31:0]          fwd_data
`endif
);

  localparam logic [REG_IDX_W-1:0] LINK_IDX    = REG_IDX_W'(LINK_REG);
  localparam logic [7:0]           TIMEOUT_CNT = 8'(LOAD_TIMEOUT);

  // Decode
  logic [5:0]           w_opcode;
  logic [5:0]           w_funct;
  logic                 w_has_dest;
  logic [REG_IDX_W-1:0] w_dest;
  wb_src_e              w_src;
  logic                 w_is_load;
  logic [31:0]          w_load_value;
  logic [31:0]          w_value;

  // FSM
  wb_state_e            r_state;
  wb_state_e            w_state_next;
  logic [7:0]           r_wait_cnt;
  logic [7:0]           w_wait_cnt_next;
  logic                 w_capture;
  logic                 w_stall;
  logic                 w_err_set;

  // WB registers
  logic                 r_wb_valid;
  logic                 r_has_dest;
  logic [REG_IDX_W-1:0] r_dest;
  logic [31:0]          r_value;
  logic [3:0]           r_inst_num;
  logic [3:0]           r_inst_type;
  logic [31:0]          r_retire;
  logic                 r_load_err;

  // Register-number fields not needed by write-back.
  logic w_unused;
  assign w_unused = ^{mem_inst[25:21], mem_inst[10:6]};

  assign w_opcode = mem_inst[31:26];
  assign w_funct  = mem_inst[5:0];

  always_comb begin
    w_has_dest = 1'b0;
    w_dest     = '0;
    w_src      = SRC_NONE;
    case (w_opcode)
      OP_RTYPE: begin
        if (w_funct != FUNCT_JR) begin
          w_has_dest = 1'b1;
          w_dest     = mem_inst[15:11];
          w_src      = SRC_ALU;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        w_has_dest = 1'b1;
        w_dest     = mem_inst[20:16];
        w_src      = SRC_ALU;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        w_has_dest = 1'b1;
        w_dest     = mem_inst[20:16];
        w_src      = SRC_LOAD;
      end
      OP_JAL: begin
        w_has_dest = 1'b1;
        w_dest     = LINK_IDX;
        w_src      = SRC_PC;
      end
      default: begin
        w_has_dest = 1'b0;
        w_dest     = '0;
        w_src      = SRC_NONE;
      end
    endcase
  end

  assign w_is_load = (w_src == SRC_LOAD);

  load_extract u_load_extract (
    .i_word   (mem_load_data),
    .i_addr   (mem_alu_output[1:0]),
    .i_opcode (w_opcode),
    .o_value  (w_load_value)
  );

  always_comb begin
    w_value = mem_alu_output;
    case (w_src)
      SRC_LOAD: w_value = w_load_value;
      SRC_PC:   w_value = mem_new_pc;
      default:  w_value = mem_alu_output;
    endcase
  end

  // Next-state / control. The MEM stage holds the load steady while we
  // stall, so WAIT_LOAD keeps decoding the live mem_* inputs.
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_capture       = 1'b0;
    w_stall         = 1'b0;
    w_err_set       = 1'b0;
    case (r_state)
      RUN: begin
        if (mem_valid && !flush_in) begin
          if (w_is_load && !mem_load_ready) begin
            w_stall         = 1'b1;
            w_state_next    = WAIT_LOAD;
            w_wait_cnt_next = 8'd1;
          end else begin
            w_capture = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (flush_in) begin
          w_state_next = RUN;
        end else if (mem_load_ready) begin
          w_capture    = 1'b1;
          w_state_next = RUN;
        end else if (r_wait_cnt >= TIMEOUT_CNT) begin
          // Give up: stall released this cycle, load leaves as a bubble.
          w_err_set    = 1'b1;
          w_state_next = RUN;
        end else begin
          w_stall         = 1'b1;
          w_wait_cnt_next = r_wait_cnt + 8'd1;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_wb_valid  <= 1'b0;
      r_has_dest  <= 1'b0;
      r_dest      <= '0;
      r_value     <= '0;
      r_inst_num  <= '0;
      r_inst_type <= '0;
      r_retire    <= '0;
      r_load_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_wb_valid <= w_capture;
      if (w_capture) begin
        r_has_dest  <= w_has_dest;
        r_dest      <= w_dest;
        r_value     <= w_value;
        r_inst_num  <= mem_inst_num;
        r_inst_type <= mem_inst_type;
        // Counted on the same edge wb_valid rises, so the count already
        // includes the instruction currently in WB.
        r_retire    <= r_retire + 32'd1;
      end
      if (w_err_set) begin
        r_load_err <= 1'b1;
      end
    end
  end

  // stall_out is combinational from mem_* inputs; gate it so reset forces 0.
  assign stall_out    = w_stall & reset;
  assign reg_we       = r_wb_valid & r_has_dest & (r_dest != '0);
  assign reg_waddr    = r_dest;
  assign reg_wdata    = r_value;
  assign wb_valid     = r_wb_valid;
  assign wb_inst_num  = r_inst_num;
  assign wb_inst_type = r_inst_type;
  assign retire_count = r_retire;
  assign load_err     = r_load_err;

`ifdef WB_FORWARD_EN
  assign fwd_valid = reg_we;
  assign fwd_addr  = reg_waddr;
  assign fwd_data  = reg_wdata;
`endif

endmodule

// File: tb/tb_stage_writeback.sv
// -----------------------------------------------------------------------------
// tb_stage_writeback
// Directed stimulus with a scoreboard queue of expected write-back results;
// a negedge monitor pops and compares whenever wb_valid is high, and also
// compares stall_out / load_err against expected values set by the stimulus.
// -----------------------------------------------------------------------------
module tb_stage_writeback;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush_in = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_inst = '0;
  logic [31:0] mem_new_pc = '0;
  logic [31:0] mem_alu_output = '0;
  logic [31:0] mem_load_data = '0;
  logic        mem_load_ready = 1'b0;
  logic [3:0]  mem_inst_num = '0;
  logic [3:0]  mem_inst_type = '0;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        stall_out;
  logic        wb_valid;
  logic [3:0]  wb_inst_num;
  logic [3:0]  wb_inst_type;
  logic [31:0] retire_count;
  logic        load_err;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif

  stage_writeback #(.LOAD_TIMEOUT(16), .LINK_REG(31)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush_in       (flush_in),
    .mem_valid      (mem_valid),
    .mem_inst       (mem_inst),
    .mem_new_pc     (mem_new_pc),
    .mem_alu_output (mem_alu_output),
    .mem_load_data  (mem_load_data),
    .mem_load_ready (mem_load_ready),
    .mem_inst_num   (mem_inst_num),
    .mem_inst_type  (mem_inst_type),
    .reg_we         (reg_we),
    .reg_waddr      (reg_waddr),
    .reg_wdata      (reg_wdata),
    .stall_out      (stall_out),
    .wb_valid       (wb_valid),
    .wb_inst_num    (wb_inst_num),
    .wb_inst_type   (wb_inst_type),
    .retire_count   (retire_count),
    .load_err       (load_err)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid      (fwd_valid),
    .fwd_addr       (fwd_addr),
    .fwd_data       (fwd_data)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  num;
    logic [3:0]  typ;
    logic [31:0] retire;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic        exp_stall = 1'b0;
  logic        exp_err = 1'b0;
  logic        chk_ctl = 1'b0;
  logic        end_req = 1'b0;
  logic        end_done = 1'b0;
  logic [31:0] exp_retire = '0;
  logic [3:0]  tag = 4'd0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("reset_we", 32'(reg_we), 32'd0);
        chk("reset_waddr", 32'(reg_waddr), 32'd0);
        chk("reset_wdata", reg_wdata, 32'd0);
        chk("reset_stall", 32'(stall_out), 32'd0);
        chk("reset_valid", 32'(wb_valid), 32'd0);
        chk("reset_retire", retire_count, 32'd0);
        chk("reset_err", 32'(load_err), 32'd0);
      end else begin
        if (chk_ctl) begin
          chk("stall_out", 32'(stall_out), 32'(exp_stall));
          chk("load_err", 32'(load_err), 32'(exp_err));
        end
        if (wb_valid) begin
          if (sb_q.size() == 0) begin
            chk("wb_extra", 32'(wb_valid), 32'd0);
          end else begin
            e = sb_q.pop_front();
            $display("WB tag=%0d we=%0b addr=%0d data=%h retire=%0d",
                     wb_inst_num, reg_we, reg_waddr, reg_wdata, retire_count);
            chk("reg_we", 32'(reg_we), 32'(e.we));
            chk("retire_count", retire_count, e.retire);
            chk("wb_inst_num", 32'(wb_inst_num), 32'(e.num));
            chk("wb_inst_type", 32'(wb_inst_type), 32'(e.typ));
            if (e.we) begin
              chk("reg_waddr", 32'(reg_waddr), 32'(e.addr));
              chk("reg_wdata", reg_wdata, e.data);
            end
          end
        end
      end
      if (end_req && !end_done) begin
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        end_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic go_idle();
    mem_valid      = 1'b0;
    flush_in       = 1'b0;
    mem_load_ready = 1'b0;
    exp_stall      = 1'b0;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] alu,
                       input logic [31:0] ld, input logic rdy,
                       input logic [31:0] pc, input logic flush);
    tag            = tag + 4'd1;
    mem_valid      = 1'b1;
    mem_inst       = inst;
    mem_alu_output = alu;
    mem_load_data  = ld;
    mem_load_ready = rdy;
    mem_new_pc     = pc;
    flush_in       = flush;
    mem_inst_num   = tag;
    mem_inst_type  = ~tag;
  endtask

  task automatic expect_wb(input logic we, input logic [4:0] addr,
                           input logic [31:0] data);
    exp_t e;
    exp_retire = exp_retire + 32'd1;
    e.we = we; e.addr = addr; e.data = data;
    e.num = tag; e.typ = ~tag; e.retire = exp_retire;
    sb_q.push_back(e);
  endtask

  // One-cycle instruction that completes immediately.
  task automatic write_op(input logic [31:0] inst, input logic [31:0] alu,
                          input logic [31:0] ld, input logic [31:0] pc,
                          input logic we, input logic [4:0] addr,
                          input logic [31:0] data);
    drive(inst, alu, ld, 1'b1, pc, 1'b0);
    exp_stall = 1'b0;
    expect_wb(we, addr, data);
    tick();
  endtask

  initial begin
    repeat (3) tick();
    reset   = 1'b1;
    chk_ctl = 1'b1;
    tick();

    // Basic ALU / load-extract / JAL / no-write cases
    write_op(32'h2008_0005, 32'h0000_0005, 32'h0, 32'h4, 1'b1, 5'd8, 32'h0000_0005);
    write_op(32'h8009_0100, 32'h0000_0100, 32'h80FF_1234, 32'h8, 1'b1, 5'd9, 32'hFFFF_FF80);
    write_op(32'h900A_0101, 32'h0000_0101, 32'h80FF_1234, 32'hC, 1'b1, 5'd10, 32'h0000_00FF);
    write_op(32'h840C_0000, 32'h0000_0100, 32'h80FF_1234, 32'h10, 1'b1, 5'd12, 32'hFFFF_80FF);
    write_op(32'h940D_0002, 32'h0000_0102, 32'h80FF_1234, 32'h14, 1'b1, 5'd13, 32'h0000_1234);
    write_op(32'h0022_0020, 32'h0000_0077, 32'h0, 32'h18, 1'b0, 5'd0, 32'h0);
    write_op(32'h0022_2825, 32'h0000_A5A5, 32'h0, 32'h1C, 1'b1, 5'd5, 32'h0000_A5A5);
    write_op(32'h0C00_0010, 32'h0000_0000, 32'h0, 32'h0000_0040, 1'b1, 5'd31, 32'h0000_0040);
    write_op(32'hAC08_0000, 32'h0000_0300, 32'h0, 32'h24, 1'b0, 5'd0, 32'h0);
    write_op(32'h03E0_0008, 32'h0000_0000, 32'h0, 32'h28, 1'b0, 5'd0, 32'h0);
    write_op(32'h3C0E_1234, 32'h1234_0000, 32'h0, 32'h2C, 1'b1, 5'd14, 32'h1234_0000);
    go_idle();
    tick();

    // Flushed instructions produce nothing and never stall
    drive(32'h2008_0009, 32'h9, 32'h0, 1'b1, 32'h30, 1'b1);
    exp_stall = 1'b0;
    tick();
    drive(32'h8C0B_0200, 32'h200, 32'h0, 1'b0, 32'h34, 1'b1);
    exp_stall = 1'b0;
    tick();
    go_idle();
    tick();

    // LW with ready low for three cycles, then one write
    drive(32'h8C0B_0200, 32'h200, 32'hDEAD_BEEF, 1'b0, 32'h38, 1'b0);
    exp_stall = 1'b1;
    repeat (3) tick();
    mem_load_ready = 1'b1;
    exp_stall      = 1'b0;
    expect_wb(1'b1, 5'd11, 32'hDEAD_BEEF);
    tick();
    go_idle();
    repeat (2) tick();

    // Ready never arrives: 16 stalled cycles, then released with load_err
    drive(32'h8C0B_0204, 32'h204, 32'h1111_1111, 1'b0, 32'h3C, 1'b0);
    exp_stall = 1'b1;
    repeat (16) tick();
    exp_stall = 1'b0;
    tick();
    go_idle();
    exp_err = 1'b1;
    repeat (2) tick();
    write_op(32'h2008_0003, 32'h3, 32'h0, 32'h40, 1'b1, 5'd8, 32'h3);
    go_idle();
    tick();

    // Flush while waiting on a load
    drive(32'h8C0B_0208, 32'h208, 32'h0, 1'b0, 32'h44, 1'b0);
    exp_stall = 1'b1;
    tick();
    flush_in  = 1'b1;
    exp_stall = 1'b0;
    tick();
    go_idle();
    repeat (2) tick();

    // Reset in the middle of WAIT_LOAD
    drive(32'h8C0B_020C, 32'h20C, 32'h0, 1'b0, 32'h48, 1'b0);
    exp_stall = 1'b1;
    repeat (2) tick();
    reset      = 1'b0;
    exp_retire = '0;
    exp_err    = 1'b0;
    repeat (2) tick();
    go_idle();
    tick();
    reset = 1'b1;
    tick();
    write_op(32'h2008_0005, 32'h5, 32'h0, 32'h4, 1'b1, 5'd8, 32'h5);
    go_idle();
    repeat (3) tick();

    end_req = 1'b1;
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
